dif_radix2_64p_sdf_bf: RTL and testbench

Radix-2 DIF single-path delay-feedback (SDF) butterfly stage for the 64-point FFT. It sits directly upstream of the twiddle multiplier. It consumes a natural-order complex sample stream and emits butterfly sums, then differences, each one bit wider. It also emits the in-frame output index that downstream logic maps onto the multiplier's control word.

---
 rtl/dif_radix2_64p_sdf_bf_pkg.sv | 20 ++
 rtl/dif_sdf_delay_line.sv | 26 ++
 rtl/dif_radix2_64p_sdf_bf.sv | 118 +++++++++++
 tb/tb_dif_radix2_64p_sdf_bf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dif_radix2_64p_sdf_bf_pkg.sv
// rtl/dif_radix2_64p_sdf_bf_pkg.sv - shared types and constants for the 64-point radix-2 DIF SDF stages
package dif_radix2_64p_sdf_bf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } bf_state_e;

    localparam int BF_DW_IN    = 10;
    localparam int BF_DW_OUT   = 11;
    localparam int FFT_N       = 64;
    localparam int FFT_STAGES  = $clog2(FFT_N);

    // Feedback depth of stage s: 32, 16, 8, 4, 2 for s = 0..4.
    function automatic int stage_delay(input int s);
        return FFT_N >> (s + 1);
    endfunction

endpackage

// File: rtl/dif_sdf_delay_line.sv
// rtl/dif_sdf_delay_line.sv - enable-gated feedback shift register, one write/read per enabled cycle
module dif_sdf_delay_line #(
    parameter int DATA_WIDTH = 22,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care until overwritten, so no reset is needed.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= wr_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign head_o = mem_q[DEPTH-1];

endmodule

// File: rtl/dif_radix2_64p_sdf_bf.sv
// rtl/dif_radix2_64p_sdf_bf.sv - radix-2 DIF SDF butterfly stage; DIF_BF_SYNC_OUT_EN adds dout_sync
module dif_radix2_64p_sdf_bf
    import dif_radix2_64p_sdf_bf_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = BF_DW_IN,
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
    parameter int DELAY          = stage_delay(0)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt_ctrl,
    input  logic                          frame_start,
    input  logic [DATA_WIDTH_IN-1:0]      din_real,
    input  logic [DATA_WIDTH_IN-1:0]      din_imag,
    output logic [DATA_WIDTH_OUT-1:0]     dout_real,
    output logic [DATA_WIDTH_OUT-1:0]     dout_imag,
    output logic                          dout_valid,
    output logic [$clog2(2*DELAY)-1:0]    dout_index
`ifdef DIF_BF_SYNC_OUT_EN
    ,
    output logic                          dout_sync
`endif
);

    localparam int CNT_W = $clog2(2*DELAY);
    localparam int EXT_W = DATA_WIDTH_OUT - DATA_WIDTH_IN;
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

    bf_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur, idx_d;
    logic adv, phase, valid_d;

    logic signed [DATA_WIDTH_OUT-1:0] din_re_x, din_im_x;
    logic signed [DATA_WIDTH_OUT-1:0] head_re, head_im;
    logic signed [DATA_WIDTH_OUT-1:0] wr_re, wr_im;
    logic signed [DATA_WIDTH_OUT-1:0] out_re_d, out_im_d;
    logic [2*DATA_WIDTH_OUT-1:0]      dl_head;

    logic [DATA_WIDTH_OUT-1:0] dout_real_q, dout_imag_q;
    logic [CNT_W-1:0]          dout_index_q;
    logic                      dout_valid_q;
    logic                      dout_sync_q;

    assign din_re_x = {{EXT_W{din_real[DATA_WIDTH_IN-1]}}, din_real};
    assign din_im_x = {{EXT_W{din_imag[DATA_WIDTH_IN-1]}}, din_imag};
    assign head_re  = dl_head[2*DATA_WIDTH_OUT-1:DATA_WIDTH_OUT];
    assign head_im  = dl_head[DATA_WIDTH_OUT-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_cur  = frame_start ? '0 : cnt_q;
        // IDLE ignores everything except a frame start.
        adv      = halt_ctrl && (state_q != ST_IDLE || frame_start);
        phase    = cnt_cur >= DELAY_C;
        cnt_d    = cnt_cur + CNT_W'(1);
        idx_d    = cnt_cur - DELAY_C;
        wr_re    = din_re_x;
        wr_im    = din_im_x;
        out_re_d = head_re;
        out_im_d = head_im;
        if (phase) begin
            wr_re    = head_re - din_re_x;
            wr_im    = head_im - din_im_x;
            out_re_d = head_re + din_re_x;
            out_im_d = head_im + din_im_x;
        end
        case (state_q)
            ST_IDLE: if (frame_start)        state_d = ST_FILL;
            ST_FILL: if (cnt_cur == DELAY_C) state_d = ST_RUN;
            ST_RUN:                          state_d = ST_RUN;
            default:                         state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_RUN);
    end

    dif_sdf_delay_line #(
        .DATA_WIDTH (2*DATA_WIDTH_OUT),
        .DEPTH      (DELAY)
    ) u_delay_line (
        .clk       (clk),
        .en_i      (adv && !rst),
        .wr_data_i ({wr_re, wr_im}),
        .head_o    (dl_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dout_real_q  <= '0;
            dout_imag_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_index_q <= '0;
            dout_sync_q  <= 1'b0;
        end else if (adv) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_real_q  <= out_re_d;
            dout_imag_q  <= out_im_d;
            dout_valid_q <= valid_d;
            dout_index_q <= idx_d;
            dout_sync_q  <= valid_d && (idx_d == '0);
        end
    end

    assign dout_real  = dout_real_q;
    assign dout_imag  = dout_imag_q;
    assign dout_valid = dout_valid_q;
    assign dout_index = dout_index_q;

`ifdef DIF_BF_SYNC_OUT_EN
    assign dout_sync = dout_sync_q;
`else
    logic unused_sync;
    assign unused_sync = dout_sync_q;
`endif

endmodule

// File: tb/tb_dif_radix2_64p_sdf_bf.sv
// tb/tb_dif_radix2_64p_sdf_bf.sv - directed self-checking bench for dif_radix2_64p_sdf_bf
module tb_dif_radix2_64p_sdf_bf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_ctrl = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  din_real = '0;
    logic [9:0]  din_imag = '0;
    logic [10:0] dout_real;
    logic [10:0] dout_imag;
    logic        dout_valid;
    logic [5:0]  dout_index;
`ifdef DIF_BF_SYNC_OUT_EN
    logic        dout_sync;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dif_radix2_64p_sdf_bf dut (
        .clk         (clk),
        .rst         (rst),
        .halt_ctrl   (halt_ctrl),
        .frame_start (frame_start),
        .din_real    (din_real),
        .din_imag    (din_imag),
        .dout_real   (dout_real),
        .dout_imag   (dout_imag),
        .dout_valid  (dout_valid),
        .dout_index  (dout_index)
`ifdef DIF_BF_SYNC_OUT_EN
        ,
        .dout_sync   (dout_sync)
`endif
    );

    task automatic step(input logic h, input logic fs, input int re, input int im);
        logic [31:0] r, i;
        r = re;
        i = im;
        halt_ctrl   = h;
        frame_start = fs;
        din_real    = r[9:0];
        din_imag    = i[9:0];
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1'b1, 1'b0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %0b want 0", dout_valid); end
        n_cmp++; if (dout_index !== 6'd0) begin n_bad++; $display("FAIL reset index: got %0d want 0", dout_index); end
        n_cmp++; if (dout_real !== 11'd0) begin n_bad++; $display("FAIL reset real: got %0d want 0", dout_real); end
        n_cmp++; if (dout_imag !== 11'd0) begin n_bad++; $display("FAIL reset imag: got %0d want 0", dout_imag); end
        rst = 1'b0;
        step(1'b1, 1'b0, 55, 66);
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL idle valid: got %0b want 0", dout_valid); end
    endtask

    task automatic test_constant();
        int er;
        pulse_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < ((f == 2) ? 32 : 64); c++) begin
                step(1'b1, c == 0, (f < 2) ? 100 : 0, 0);
                n_cmp++;
                if (f == 0 && c < 32) begin
                    if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL const fill c=%0d: valid %0b want 0", c, dout_valid); end
                end else begin
                    er = (c >= 32) ? 200 : 0;
                    if (dout_valid !== 1'b1 || dout_index !== 6'((c + 32) % 64) || $signed(dout_real) !== er || $signed(dout_imag) !== 0) begin
                        n_bad++;
                        $display("FAIL const f=%0d c=%0d: got v=%0b i=%0d re=%0d im=%0d want v=1 i=%0d re=%0d im=0",
                                 f, c, dout_valid, dout_index, $signed(dout_real), $signed(dout_imag), (c + 32) % 64, er);
                    end
                end
`ifdef DIF_BF_SYNC_OUT_EN
                n_cmp++;
                if (dout_sync !== (c == 32)) begin n_bad++; $display("FAIL sync f=%0d c=%0d: got %0b want %0b", f, c, dout_sync, c == 32); end
`endif
            end
        end
    endtask

    task automatic test_halt();
        int er;
        pulse_reset();
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 64; c++) begin
                for (int h = 0; h < 2; h++) begin
                    if (h == 0) step(1'b1, c == 0, 100, 0);
                    else        step(1'b0, 1'b1, 300, -77);
                    n_cmp++;
                    if (f == 0 && c < 32) begin
                        if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL halt fill c=%0d h=%0d: valid %0b want 0", c, h, dout_valid); end
                    end else begin
                        er = (c >= 32) ? 200 : 0;
                        if (dout_valid !== 1'b1 || dout_index !== 6'((c + 32) % 64) || $signed(dout_real) !== er || $signed(dout_imag) !== 0) begin
                            n_bad++;
                            $display("FAIL halt f=%0d c=%0d h=%0d: got v=%0b i=%0d re=%0d im=%0d want v=1 i=%0d re=%0d im=0",
                                     f, c, h, dout_valid, dout_index, $signed(dout_real), $signed(dout_imag), (c + 32) % 64, er);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_impulse();
        int er, ei;
        pulse_reset();
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < ((f == 1) ? 32 : 64); c++) begin
                step(1'b1, c == 0, (f == 0 && c == 0) ? 511 : 0, (f == 0 && c == 0) ? -512 : 0);
                n_cmp++;
                if (f == 0 && c < 32) begin
                    if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL imp fill c=%0d: valid %0b want 0", c, dout_valid); end
                end else begin
                    er = ((f == 0 && c == 32) || (f == 1 && c == 0)) ? 511 : 0;
                    ei = (er != 0) ? -512 : 0;
                    if (dout_valid !== 1'b1 || dout_index !== 6'((c + 32) % 64) || $signed(dout_real) !== er || $signed(dout_imag) !== ei) begin
                        n_bad++;
                        $display("FAIL imp f=%0d c=%0d: got v=%0b i=%0d re=%0d im=%0d want v=1 i=%0d re=%0d im=%0d",
                                 f, c, dout_valid, dout_index, $signed(dout_real), $signed(dout_imag), (c + 32) % 64, er, ei);
                    end
                end
            end
        end
    endtask

    task automatic test_extremes();
        int x, e;
        pulse_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < ((f == 2) ? 32 : 64); c++) begin
                if (f == 0)      x = -512;
                else if (f == 1) x = (c < 32) ? 511 : -512;
                else             x = 0;
                step(1'b1, c == 0, x, x);
                n_cmp++;
                if (f == 0 && c < 32) begin
                    if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL ext fill c=%0d: valid %0b want 0", c, dout_valid); end
                end else begin
                    if (f == 0)      e = -1024;
                    else if (f == 1) e = (c < 32) ? 0 : -1;
                    else             e = 1023;
                    if (dout_valid !== 1'b1 || dout_index !== 6'((c + 32) % 64) || $signed(dout_real) !== e || $signed(dout_imag) !== e) begin
                        n_bad++;
                        $display("FAIL ext f=%0d c=%0d: got v=%0b i=%0d re=%0d im=%0d want v=1 i=%0d re=%0d im=%0d",
                                 f, c, dout_valid, dout_index, $signed(dout_real), $signed(dout_imag), (c + 32) % 64, e, e);
                    end
                end
            end
        end
    endtask

    task automatic test_resync();
        int er, ei;
        pulse_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, c == 0, 7, 7);
            n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL resync pre c=%0d: valid %0b want 0", c, dout_valid); end
        end
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < ((f == 1) ? 32 : 64); c++) begin
                if (f == 0) step(1'b1, c == 0, (c < 32) ? c : 1, (c < 32) ? -c : 0);
                else        step(1'b1, c == 0, 0, 0);
                n_cmp++;
                if (f == 0 && c < 32) begin
                    if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL resync fill c=%0d: valid %0b want 0", c, dout_valid); end
                end else begin
                    er = (f == 0) ? (c - 32) + 1 : c - 1;
                    ei = (f == 0) ? -(c - 32) : -c;
                    if (dout_valid !== 1'b1 || dout_index !== 6'((c + 32) % 64) || $signed(dout_real) !== er || $signed(dout_imag) !== ei) begin
                        n_bad++;
                        $display("FAIL resync f=%0d c=%0d: got v=%0b i=%0d re=%0d im=%0d want v=1 i=%0d re=%0d im=%0d",
                                 f, c, dout_valid, dout_index, $signed(dout_real), $signed(dout_imag), (c + 32) % 64, er, ei);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_reset();
        for (int c = 0; c < 40; c++) step(1'b1, c == 0, 100, 0);
        n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL midrun pre valid: got %0b want 1", dout_valid); end
        rst = 1'b1;
        step(1'b1, 1'b0, 100, 0);
        rst = 1'b0;
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL midrun valid: got %0b want 0", dout_valid); end
        n_cmp++; if (dout_index !== 6'd0) begin n_bad++; $display("FAIL midrun index: got %0d want 0", dout_index); end
        n_cmp++; if (dout_real !== 11'd0 || dout_imag !== 11'd0) begin n_bad++; $display("FAIL midrun data: got %0d/%0d want 0/0", dout_real, dout_imag); end
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 50, 50);
            n_cmp++;
            if (dout_valid !== 1'b0 || dout_real !== 11'd0 || dout_index !== 6'd0) begin
                n_bad++;
                $display("FAIL midrun ignore c=%0d: got v=%0b re=%0d i=%0d want 0/0/0", c, dout_valid, dout_real, dout_index);
            end
        end
        step(1'b1, 1'b1, 50, 50);
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL midrun restart valid: got %0b want 0", dout_valid); end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_halt();
        test_impulse();
        test_extremes();
        test_resync();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
